fpu_add_arbiter: RTL

FPU_ADD_ARBITER -- requirements
Module: fpu_add_arbiter

---
 rtl/fpu_add_arbiter.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/fpu_add_arbiter.sv
// ---------------------------------------------------------------------------
// fpu_add_arbiter
//
// Shares one combinational IEEE-754 single-precision adder between two
// requesters. A request is granted in IDLE, its operands are latched and
// presented to the adder for LAT cycles (EXEC), the sum is latched and
// returned on the owner's response channel (RESP) until it is accepted.
//
// Parameters
//   LAT          cycles the operands are held on the shared adder (1..4)
//
// Optional feature
//   FPU_ARB_ROUND_ROBIN_EN  when defined, contention in IDLE is resolved in
//                           favour of the requester not granted last; when
//                           undefined, requester 0 always wins contention.
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   req0_* / req1_*         operand handshake (valid/ready, a, b)
//   rsp0_* / rsp1_*         result handshake (valid/ready, data)
//   add_a, add_b, add_out   shared adder operands and sum
//   busy                    high whenever the arbiter is not idle
// ---------------------------------------------------------------------------
module fpu_add_arbiter #(
    parameter int LAT = 1
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,

    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [31:0] rsp0_data,

    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp1_data,

    output logic [31:0] add_a,
    output logic [31:0] add_b,
    input  logic [31:0] add_out,

    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // EXEC counts down from LAT-1 to 0; LAT <= 4 fits in two bits.
    localparam logic [1:0] CNT_INIT = 2'(LAT - 1);

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] opa_q, opa_d;
    logic [31:0] opb_q, opb_d;
    logic [31:0] res_q, res_d;
    logic        busy_q, busy_d;
    logic        rsp0_valid_q, rsp0_valid_d;
    logic        rsp1_valid_q, rsp1_valid_d;

`ifdef FPU_ARB_ROUND_ROBIN_EN
    logic        last_q, last_d;
`endif

    logic        grant;
    logic        grant_sel;
    logic        rr_pick;
    logic        own_ready;

    // Winner selection: grant_sel = 1 means requester 1 is chosen.
    always_comb begin
`ifdef FPU_ARB_ROUND_ROBIN_EN
        rr_pick = ~last_q;
`else
        rr_pick = 1'b0;
`endif
        if (req0_valid) begin
            grant_sel = req1_valid & rr_pick;
        end else begin
            grant_sel = 1'b1;
        end
    end

    // A grant is only possible from IDLE; reset suppresses it so the
    // ready outputs are low while reset is asserted.
    assign grant      = (state_q == S_IDLE) && (req0_valid || req1_valid) && !reset;
    assign req0_ready = grant && !grant_sel;
    assign req1_ready = grant &&  grant_sel;

    assign own_ready  = owner_q ? rsp1_ready : rsp0_ready;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
`ifdef FPU_ARB_ROUND_ROBIN_EN
        last_d  = last_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (grant) begin
                    opa_d   = grant_sel ? req1_a : req0_a;
                    opb_d   = grant_sel ? req1_b : req0_b;
                    owner_d = grant_sel;
                    cnt_d   = CNT_INIT;
                    state_d = S_EXEC;
`ifdef FPU_ARB_ROUND_ROBIN_EN
                    last_d  = grant_sel;
`endif
                end
            end
            S_EXEC: begin
                if (cnt_q == 2'd0) begin
                    res_d   = add_out;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            S_RESP: begin
                // Returning to IDLE here means the next grant happens one
                // cycle after the response handshake, never in it.
                if (own_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status outputs are registered: decode them from the next state.
        busy_d       = (state_d != S_IDLE);
        rsp0_valid_d = (state_d == S_RESP) && !owner_d;
        rsp1_valid_d = (state_d == S_RESP) &&  owner_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            cnt_q        <= 2'd0;
            opa_q        <= 32'd0;
            opb_q        <= 32'd0;
            res_q        <= 32'd0;
            busy_q       <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
`ifdef FPU_ARB_ROUND_ROBIN_EN
            last_q       <= 1'b1;
`endif
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            opa_q        <= opa_d;
            opb_q        <= opb_d;
            res_q        <= res_d;
            busy_q       <= busy_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
`ifdef FPU_ARB_ROUND_ROBIN_EN
            last_q       <= last_d;
`endif
        end
    end

    assign add_a      = opa_q;
    assign add_b      = opb_q;
    assign rsp0_data  = res_q;
    assign rsp1_data  = res_q;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign busy       = busy_q;

endmodule
